// File: rtl/iq_mod_pkg.sv
// Shared types and constants for the O-QPSK modulator: FSM states, default
// sizing, and the constant function that builds the half-sine pulse table.
package iq_mod_pkg;

  localparam int unsigned OSR_DEF = 8;
  localparam int unsigned DW_DEF  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // sin(pi*j/32) in Q16 for j = 0..16 (first quarter wave at the finest OSR).
  function automatic int unsigned sin_q16(input int unsigned j);
    case (j)
      0:  return 0;
      1:  return 6424;
      2:  return 12785;
      3:  return 19024;
      4:  return 25080;
      5:  return 30893;
      6:  return 36410;
      7:  return 41576;
      8:  return 46341;
      9:  return 50660;
      10: return 54491;
      11: return 57797;
      12: return 60547;
      13: return 62714;
      14: return 64277;
      15: return 65220;
      16: return 65536;
      default: return 0;
    endcase
  endfunction

  // round((2^(dw-1)-1) * sin(pi*k/(2*osr))); osr must divide 16.
  function automatic int unsigned half_sine_mag(input int unsigned k,
                                                input int unsigned osr,
                                                input int unsigned dw);
    int unsigned j;
    logic [63:0] amp;
    logic [63:0] prod;
    j = k * (16 / osr);
    if (j > 16) j = 32 - j;
    amp  = (64'd1 << (dw - 1)) - 64'd1;
    prod = amp * 64'(sin_q16(j)) + 64'd32768;
    return 32'(prod >> 16);
  endfunction

endpackage

// File: rtl/half_sine_lut.sv
// Combinational half-sine magnitude ROM.
//   idx   : pulse sample index 0..2*OSR-1
//   mag_c : unsigned magnitude, DW-1 bits
module half_sine_lut
  import iq_mod_pkg::*;
#(
  parameter int unsigned OSR = OSR_DEF,
  parameter int unsigned DW  = DW_DEF,
  localparam int unsigned IDX_W = $clog2(2 * OSR),
  localparam int unsigned MAG_W = DW - 1
) (
  input  logic [IDX_W-1:0] idx,
  output logic [MAG_W-1:0] mag_c
);

  logic [MAG_W-1:0] rom [2*OSR];

  for (genvar k = 0; k < 2 * OSR; k++) begin : g_rom
    assign rom[k] = MAG_W'(half_sine_mag(32'(k), OSR, DW));
  end

  assign mag_c = rom[idx];

endmodule

// File: rtl/oqpsk_shaper.sv
// O-QPSK half-sine pulse shaper: serial chips in over valid/ready, even chips
// to I and odd chips to Q (Q lagging by one chip period), one signed I/Q
// sample pair per sample_en strobe.
//   clk, resetn          : clock, async active-low reset
//   sample_en            : sample-rate strobe
//   chip_in/chip_valid   : chip stream; chip_ready back-pressure
//   i_out/q_out          : signed samples, out_valid pulses after each strobe
//   busy                 : frame in progress
module oqpsk_shaper
  import iq_mod_pkg::*;
#(
  parameter int unsigned OSR = OSR_DEF,
  parameter int unsigned DW  = DW_DEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 sample_en,
  input  logic                 chip_in,
  input  logic                 chip_valid,
  output logic                 chip_ready,
  output logic signed [DW-1:0] i_out,
  output logic signed [DW-1:0] q_out,
  output logic                 out_valid,
  output logic                 busy
);

  localparam int unsigned IDX_W = $clog2(2 * OSR);
  localparam int unsigned CNT_W = $clog2(OSR);
  localparam int unsigned MAG_W = DW - 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(2 * OSR - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);

  typedef struct packed {
    logic             act;
    logic             sign;
    logic [IDX_W-1:0] idx;
  } branch_t;

  state_e                 state_q, state_d;
  logic                   buf_full_q, buf_full_d;
  logic                   buf_chip_q, buf_chip_d;
  logic                   sel_q, sel_d;
  logic [CNT_W-1:0]       s_cnt_q, s_cnt_d;
  branch_t [1:0]          br_q, br_d, eff;
  logic signed [DW-1:0]   i_out_d, q_out_d;
  logic                   out_valid_d, busy_d, chip_ready_d;

  logic                   boundary, consume, load;
  logic [1:0][MAG_W-1:0]  mag;
  logic [1:0][DW-1:0]     samp;

  // Boundary decode and branch reload; eff is the branch state the current strobe renders.
  always_comb begin
    boundary = sample_en && (s_cnt_q == '0);
    consume  = boundary && buf_full_q && (state_q != FLUSH);
    load     = chip_valid && chip_ready;
    eff      = br_q;
    if (consume) begin
      eff[sel_q].act  = 1'b1;
      eff[sel_q].sign = buf_chip_q;
      eff[sel_q].idx  = '0;
    end
  end

  half_sine_lut #(.OSR(OSR), .DW(DW)) u_lut_i (.idx(eff[0].idx), .mag_c(mag[0]));
  half_sine_lut #(.OSR(OSR), .DW(DW)) u_lut_q (.idx(eff[1].idx), .mag_c(mag[1]));

  // Signed sample per branch; inactive branches render zero.
  always_comb begin
    samp = '0;
    for (int b = 0; b < 2; b++) begin
      if (eff[b].act) begin
        if (eff[b].sign) samp[b] = {1'b0, mag[b]};
        else             samp[b] = DW'(0) - {1'b0, mag[b]};
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    buf_full_d   = load | (buf_full_q & ~consume);
    buf_chip_d   = buf_chip_q;
    sel_d        = sel_q;
    s_cnt_d      = s_cnt_q;
    br_d         = br_q;
    i_out_d      = i_out;
    q_out_d      = q_out;
    out_valid_d  = sample_en;

    case (state_q)
      IDLE:    if (consume) state_d = RUN;
      RUN:     if (boundary && !buf_full_q) state_d = FLUSH;
      FLUSH:   if (!br_q[0].act && !br_q[1].act) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (load)    buf_chip_d = chip_in;
    if (consume) sel_d = ~sel_q;

    if (sample_en) begin
      for (int b = 0; b < 2; b++) begin
        br_d[b] = eff[b];
        if (eff[b].act) begin
          br_d[b].idx = eff[b].idx + IDX_W'(1);
          if (eff[b].idx == IDX_LAST) br_d[b].act = 1'b0;
        end
      end
      i_out_d = samp[0];
      q_out_d = samp[1];
      s_cnt_d = (s_cnt_q == CNT_LAST) ? '0 : s_cnt_q + CNT_W'(1);
    end

    // Idle always re-arms on I with the strobe counter at a boundary.
    if (state_d == IDLE) begin
      s_cnt_d = '0;
      sel_d   = 1'b0;
    end

    busy_d       = (state_d != IDLE);
    chip_ready_d = !buf_full_d && (state_d != FLUSH);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      buf_full_q <= 1'b0;
      buf_chip_q <= 1'b0;
      sel_q      <= 1'b0;
      s_cnt_q    <= '0;
      br_q       <= '0;
      i_out      <= '0;
      q_out      <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      chip_ready <= 1'b1;
    end else begin
      state_q    <= state_d;
      buf_full_q <= buf_full_d;
      buf_chip_q <= buf_chip_d;
      sel_q      <= sel_d;
      s_cnt_q    <= s_cnt_d;
      br_q       <= br_d;
      i_out      <= i_out_d;
      q_out      <= q_out_d;
      out_valid  <= out_valid_d;
      busy       <= busy_d;
      chip_ready <= chip_ready_d;
    end
  end

endmodule
